// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_e;

  localparam int unsigned SYNC_BITS    = 8;
  localparam logic [7:0]  SYNC_PATTERN = 8'h80;

  // Line encodings as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // NRZI: a 0 toggles J<->K, a 1 holds the current level
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic tx_bit);
    nrzi_next = tx_bit ? line : ((line == LINE_J) ? LINE_K : LINE_J);
  endfunction

endpackage

// File: rtl/usb_bit_strobe.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, strobes on the last count.
module usb_bit_strobe #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic bit_strobe_c
);

  localparam int unsigned    CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign bit_strobe_c = en & ~clr & (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, fed through a one-entry holding buffer.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_last,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              busy,
  output logic              underrun,
  output logic              dplus,
  output logic              dminus
);

  localparam int unsigned IDX_MAX0 = (DATA_W > SYNC_BITS) ? DATA_W : SYNC_BITS;
  localparam int unsigned IDX_MAX  = (EOP_SE0_BITS > IDX_MAX0) ? EOP_SE0_BITS : IDX_MAX0;
  localparam int unsigned IDX_W    = $clog2(IDX_MAX);
  localparam int unsigned STUFF_W  = $clog2(STUFF_LEN + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_last_q, hold_last_d;
  logic                hold_full_q, hold_full_d;
  logic [STUFF_W-1:0]  stuff_cnt_q, stuff_cnt_d;
  logic [1:0]          line_q, line_d;
  logic                busy_q, busy_d;
  logic                data_ready_q, data_ready_d;
  logic                underrun_q, underrun_d;

  logic                bit_strobe_c;
  logic                tx_go, tx_bit, load, eop_go, word_end;
  logic [1:0]          tx_base;
  logic [STUFF_W-1:0]  cnt_base;
  logic [IDX_W-1:0]    next_idx;

  usb_bit_strobe #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_strobe (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (state_q != IDLE),
    .clr         (state_q == IDLE),
    .bit_strobe_c(bit_strobe_c)
  );

  assign next_idx = idx_q + IDX_W'(1);
  assign word_end = (state_q == SYNC) ? (idx_q == IDX_W'(SYNC_BITS - 1))
                                      : (idx_q == IDX_W'(DATA_W - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    last_d       = last_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    stuff_cnt_d  = stuff_cnt_q;
    line_d       = line_q;
    underrun_d   = 1'b0;
    tx_go        = 1'b0;
    tx_bit       = 1'b0;
    tx_base      = line_q;
    cnt_base     = stuff_cnt_q;
    load         = 1'b0;
    eop_go       = 1'b0;

    if (data_valid && data_ready_q) begin
      hold_d      = data_in;
      hold_last_d = data_last;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SYNC;
          idx_d    = '0;
          tx_go    = 1'b1;
          tx_bit   = SYNC_PATTERN[0];
          tx_base  = LINE_J;
          cnt_base = '0;
        end
      end
      SYNC, DATA: begin
        if (bit_strobe_c) begin
          // An inserted zero leaves the index and shifter untouched
          if (stuff_cnt_q == STUFF_W'(STUFF_LEN)) begin
            tx_go  = 1'b1;
            tx_bit = 1'b0;
          end else if (!word_end) begin
            idx_d = next_idx;
            tx_go = 1'b1;
            if (state_q == SYNC) begin
              tx_bit = SYNC_PATTERN[next_idx[2:0]];
            end else begin
              tx_bit  = shift_q[1];
              shift_d = shift_q >> 1;
            end
          end else if ((state_q == DATA) && last_q) begin
            eop_go = 1'b1;
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            underrun_d = 1'b1;
            eop_go     = 1'b1;
          end
        end
      end
      EOP_SE0: begin
        if (bit_strobe_c) begin
          if (idx_q == IDX_W'(EOP_SE0_BITS - 1)) begin
            state_d = EOP_J;
            line_d  = LINE_J;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      EOP_J: begin
        if (bit_strobe_c) begin
          state_d     = IDLE;
          hold_full_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = LINE_J;
      end
    endcase

    if (load) begin
      state_d     = DATA;
      idx_d       = '0;
      shift_d     = hold_q;
      last_d      = hold_last_q;
      hold_full_d = 1'b0;
      tx_go       = 1'b1;
      tx_bit      = hold_q[0];
    end

    if (tx_go) begin
      line_d      = nrzi_next(tx_base, tx_bit);
      stuff_cnt_d = tx_bit ? cnt_base + STUFF_W'(1) : '0;
    end

    if (eop_go) begin
      state_d = EOP_SE0;
      idx_d   = '0;
      line_d  = LINE_SE0;
    end

    busy_d       = (state_d != IDLE);
    data_ready_d = busy_d & ~hold_full_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      stuff_cnt_q  <= '0;
      line_q       <= LINE_J;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      stuff_cnt_q  <= stuff_cnt_d;
      line_q       <= line_d;
      busy_q       <= busy_d;
      data_ready_q <= data_ready_d;
      underrun_q   <= underrun_d;
    end
  end

  assign data_ready = data_ready_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign dplus      = line_q[1];
  assign dminus     = line_q[0];

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: table vectors, hand sequences and
// random packets checked against a bit-stream level line model.
module tb_usb_tx_serializer;

  localparam int unsigned C8   = 8;
  localparam int unsigned C16  = 4;
  localparam int unsigned SL   = 6;
  localparam int unsigned SE0B = 2;

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][15:0] w;
    logic             last;
    logic [7:0]       periods;
    logic [1:0]       urs;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start, data_last, data_valid;
  logic [7:0]  data_in;
  logic        data_ready, busy, underrun, dplus, dminus;
  logic        start16, last16, valid16;
  logic [15:0] data16;
  logic        ready16, busy16, ur16, dp16, dm16;

  always #5 clk = ~clk;

  usb_tx_serializer #(.CLKS_PER_BIT(C8), .DATA_W(8), .STUFF_LEN(SL), .EOP_SE0_BITS(SE0B)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in), .data_last(data_last),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .underrun(underrun),
    .dplus(dplus), .dminus(dminus)
  );

  usb_tx_serializer #(.CLKS_PER_BIT(C16), .DATA_W(16), .STUFF_LEN(SL), .EOP_SE0_BITS(SE0B)) dut16 (
    .clk(clk), .n_rst(n_rst), .start(start16), .data_in(data16), .data_last(last16),
    .data_valid(valid16), .data_ready(ready16), .busy(busy16), .underrun(ur16),
    .dplus(dp16), .dminus(dm16)
  );

  int         vectors = 0;
  int         errors  = 0;
  int         ur8_cnt, ur16_cnt;
  logic [1:0] cap8[$];
  logic [1:0] cap16[$];
  logic [1:0] exp_q[$];
  vec_t       tbl[8];

  // Record the line every cycle the transmitter reports busy
  always @(negedge clk) begin
    if (busy) cap8.push_back({dplus, dminus});
    if (underrun) ur8_cnt++;
    if (busy16) cap16.push_back({dp16, dm16});
    if (ur16) ur16_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [3:0][15:0] mkw(input logic [15:0] a, b, c, d);
    logic [3:0][15:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic vec_t mkv(input int n, input logic [3:0][15:0] w, input bit last,
                               input int periods, input int urs);
    vec_t v;
    v.n = 3'(n); v.w = w; v.last = last; v.periods = 8'(periods); v.urs = 2'(urs);
    return v;
  endfunction

  // Expected line per bit period: SYNC+data bit stream, stuffing, NRZI, then EOP
  task automatic build_exp(input int w, input int n, input logic [3:0][15:0] words,
                           output int data_periods);
    logic [1:0]  line;
    logic [7:0]  sync;
    logic [15:0] cur;
    int          ones;
    logic        b;
    exp_q.delete();
    line = 2'b10;
    ones = 0;
    sync = 8'h80;
    for (int i = 0; i < 8 + n * w; i++) begin
      if (i < 8) begin
        b = sync[i];
      end else begin
        cur = words[(i - 8) / w];
        b   = cur[(i - 8) % w];
      end
      if (!b) line = ~line;
      exp_q.push_back(line);
      ones = b ? ones + 1 : 0;
      if (ones == SL) begin
        line = ~line;
        exp_q.push_back(line);
        ones = 0;
      end
    end
    data_periods = exp_q.size();
    for (int i = 0; i < SE0B; i++) exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  task automatic compare_line(input string name, input bit use16);
    int         cpb, len, idx;
    logic [1:0] g, got;
    bit         bad;
    cpb = use16 ? C16 : C8;
    len = use16 ? cap16.size() : cap8.size();
    check($sformatf("%s busy_cycles", name), len, exp_q.size() * cpb);
    for (int p = 0; p < exp_q.size(); p++) begin
      bad = 1'b0;
      got = exp_q[p];
      for (int k = 0; k < cpb; k++) begin
        idx = p * cpb + k;
        if (idx < len) g = use16 ? cap16[idx] : cap8[idx];
        else g = 2'bxx;
        if (!bad && g !== exp_q[p]) begin
          bad = 1'b1;
          got = g;
        end
      end
      check($sformatf("%s period%0d line", name, p), got, exp_q[p]);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("%s busy_end", name), busy, 0);
  endtask

  task automatic send8(input string name, input int n, input logic [3:0][15:0] words,
                       input bit last_flag, input bit extra_start);
    int t;
    cap8.delete();
    ur8_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_in    = words[i][7:0];
      data_last  = last_flag && (i == n - 1);
      if (extra_start && i == 0) start = 1'b1;
      t = 0;
      while (!data_ready && t < 2000) begin
        @(negedge clk);
        start = 1'b0;
        t++;
      end
      if (t >= 2000) check($sformatf("%s ready_wait", name), t, 0);
      @(negedge clk);
      start = 1'b0;
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    int               dp, t;
    logic [3:0][15:0] w;
    int               n;

    n_rst = 1'b0; start = 1'b0; data_last = 1'b0; data_valid = 1'b0; data_in = '0;
    start16 = 1'b0; last16 = 1'b0; valid16 = 1'b0; data16 = '0;
    ur8_cnt = 0; ur16_cnt = 0;

    tbl[0] = mkv(1, mkw(16'h00, 0, 0, 0), 1'b1, 16, 0);
    tbl[1] = mkv(1, mkw(16'hFF, 0, 0, 0), 1'b1, 17, 0);
    tbl[2] = mkv(2, mkw(16'h3F, 16'h01, 0, 0), 1'b1, 25, 0);
    tbl[3] = mkv(1, mkw(16'hA5, 0, 0, 0), 1'b0, 16, 1);
    tbl[4] = mkv(0, mkw(0, 0, 0, 0), 1'b0, 8, 1);
    tbl[5] = mkv(2, mkw(16'hFF, 16'hFF, 0, 0), 1'b1, 26, 0);
    tbl[6] = mkv(1, mkw(16'h7E, 0, 0, 0), 1'b1, 17, 0);
    tbl[7] = mkv(1, mkw(16'hFC, 0, 0, 0), 1'b1, 17, 0);

    repeat (3) @(negedge clk);
    check("reset line", {dplus, dminus}, 2'b10);
    check("reset busy", busy, 0);
    check("reset data_ready", data_ready, 0);
    check("reset underrun", underrun, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      build_exp(8, int'(tbl[i].n), tbl[i].w, dp);
      check($sformatf("tbl%0d periods", i), dp, int'(tbl[i].periods));
      send8($sformatf("tbl%0d", i), int'(tbl[i].n), tbl[i].w, tbl[i].last, 1'b0);
      compare_line($sformatf("tbl%0d", i), 1'b0);
      check($sformatf("tbl%0d underruns", i), ur8_cnt, int'(tbl[i].urs));
      @(negedge clk);
    end

    // Handshake timing: ready in SYNC, drops the cycle after each transfer
    build_exp(8, 2, mkw(16'h00, 16'h55, 0, 0), dp);
    cap8.delete();
    ur8_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs busy_rise", busy, 1);
    check("hs ready_in_sync", data_ready, 1);
    check("hs first_sync_bit", {dplus, dminus}, 2'b01);
    data_valid = 1'b1; data_in = 8'h00; data_last = 1'b0;
    @(negedge clk);
    check("hs ready_after_xfer1", data_ready, 0);
    data_in = 8'h55; data_last = 1'b1;
    t = 0;
    while (!data_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    data_valid = 1'b0; data_last = 1'b0;
    check("hs ready_after_xfer2", data_ready, 0);
    wait_idle("hs");
    compare_line("hs", 1'b0);
    check("hs underruns", ur8_cnt, 0);

    // Second start during SYNC must not produce a second packet
    build_exp(8, 1, mkw(16'h00, 0, 0, 0), dp);
    send8("dblstart", 1, mkw(16'h00, 0, 0, 0), 1'b1, 1'b1);
    compare_line("dblstart", 1'b0);
    repeat (3) @(negedge clk);
    check("dblstart stays_idle", busy, 0);

    // Reset in the middle of the data field
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_valid = 1'b1; data_in = 8'h00; data_last = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; data_last = 1'b0;
    repeat (90) @(negedge clk);
    check("midrst busy_before", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check("midrst line", {dplus, dminus}, 2'b10);
    check("midrst busy", busy, 0);
    check("midrst data_ready", data_ready, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // 16-bit words at 4 clocks per bit
    build_exp(16, 1, mkw(16'h8001, 0, 0, 0), dp);
    check("w16 periods", dp, 24);
    cap16.delete();
    ur16_cnt = 0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; valid16 = 1'b1; data16 = 16'h8001; last16 = 1'b1;
    check("w16 ready", ready16, 1);
    @(negedge clk);
    valid16 = 1'b0; last16 = 1'b0;
    t = 0;
    while (busy16 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("w16 busy_end", busy16, 0);
    compare_line("w16", 1'b1);
    check("w16 underruns", ur16_cnt, 0);

    // Random packets, biased toward runs of ones
    for (int r = 0; r < 16; r++) begin
      n = int'($urandom_range(1, 3));
      w = '0;
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: w[i] = 16'($urandom_range(0, 255));
          1: w[i] = 16'hFF;
          2: w[i] = 16'hFE;
          default: w[i] = 16'h7F;
        endcase
      end
      build_exp(8, n, w, dp);
      send8($sformatf("rnd%0d", r), n, w, 1'b1, 1'b0);
      compare_line($sformatf("rnd%0d", r), 1'b0);
      check($sformatf("rnd%0d underruns", r), ur8_cnt, 0);
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
